// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two word-aligned reads per load, then
// extracts, shifts and sign/zero-extends the addressed bytes for writeback.
module load_align_unit #(
   parameter int XLEN        = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_fn3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [4:0]      req_rd,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic [4:0]      rsp_rd,
   output logic            rsp_err
);

   localparam int WB   = XLEN / 8;
   localparam int OFFW = $clog2(WB);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ISSUE0 = 3'd1;
   localparam logic [2:0] WAIT0  = 3'd2;
   localparam logic [2:0] ISSUE1 = 3'd3;
   localparam logic [2:0] WAIT1  = 3'd4;
   localparam logic [2:0] RESP   = 3'd5;

   function automatic logic [3:0] size_f(input logic [1:0] sz);
      case (sz)
         2'b00:   size_f = 4'd1;
         2'b01:   size_f = 4'd2;
         2'b10:   size_f = 4'd4;
         default: size_f = 4'd8;
      endcase
   endfunction

   function automatic logic legal_f(input logic [2:0] fn3);
      if (fn3 == 3'b111) begin
         legal_f = 1'b0;
      end else if ((XLEN == 32) && ((fn3 == 3'b011) || (fn3 == 3'b110))) begin
         legal_f = 1'b0;
      end else begin
         legal_f = 1'b1;
      end
   endfunction

   // Shift the two-word window down by the byte offset, keep the field, extend from its top bit.
   function automatic logic [XLEN-1:0] extract_f(input logic [2:0]      fn3,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [XLEN-1:0] w0,
                                                 input logic [XLEN-1:0] w1);
      logic [6:0]      sh_s;
      logic [6:0]      nbits_s;
      logic [XLEN-1:0] low_s;
      logic [XLEN-1:0] mask_s;
      logic            sign_s;
      sh_s      = 7'({off, 3'b000});
      low_s     = (w0 >> sh_s) | (w1 << (7'(XLEN) - sh_s));
      nbits_s   = {size_f(fn3[1:0]), 3'b000};
      mask_s    = ~({XLEN{1'b1}} << nbits_s);
      sign_s    = (|(low_s & (mask_s ^ (mask_s >> 1)))) & ~fn3[2];
      extract_f = (low_s & mask_s) | (sign_s ? ~mask_s : {XLEN{1'b0}});
   endfunction

   logic [OFFW-1:0] off_s;
   logic [XLEN-1:0] base_s;
   logic [4:0]      end_s;
   logic            cross_s;
   logic            reject_s;

   assign off_s    = req_addr[OFFW-1:0];
   assign base_s   = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
   assign end_s    = 5'(off_s) + 5'(size_f(req_fn3[1:0]));
   assign cross_s  = end_s > 5'(WB);
   assign reject_s = !legal_f(req_fn3) || (cross_s && !MISALIGN_EN);

   logic [2:0]      state_r;
   logic [2:0]      fn3_r;
   logic [OFFW-1:0] off_r;
   logic [XLEN-1:0] base_r;
   logic [4:0]      rd_r;
   logic            cross_r;
   logic [XLEN-1:0] word0_r;
   logic            req_ready_r;
   logic            mem_req_valid_r;
   logic [XLEN-1:0] mem_req_addr_r;
   logic            rsp_valid_r;
   logic [XLEN-1:0] rsp_data_r;
   logic [4:0]      rsp_rd_r;
   logic            rsp_err_r;

   // Transaction sequencer; all outputs are registered and change only on state transitions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= IDLE;
         fn3_r           <= 3'b000;
         off_r           <= {OFFW{1'b0}};
         base_r          <= {XLEN{1'b0}};
         rd_r            <= 5'd0;
         cross_r         <= 1'b0;
         word0_r         <= {XLEN{1'b0}};
         req_ready_r     <= 1'b1;
         mem_req_valid_r <= 1'b0;
         mem_req_addr_r  <= {XLEN{1'b0}};
         rsp_valid_r     <= 1'b0;
         rsp_data_r      <= {XLEN{1'b0}};
         rsp_rd_r        <= 5'd0;
         rsp_err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  fn3_r       <= req_fn3;
                  off_r       <= off_s;
                  base_r      <= base_s;
                  rd_r        <= req_rd;
                  cross_r     <= cross_s;
                  req_ready_r <= 1'b0;
                  if (reject_s) begin
                     state_r     <= RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b1;
                     rsp_data_r  <= {XLEN{1'b0}};
                     rsp_rd_r    <= req_rd;
                  end else begin
                     state_r         <= ISSUE0;
                     mem_req_valid_r <= 1'b1;
                     mem_req_addr_r  <= base_s;
                  end
               end
            end
            ISSUE0: begin
               if (mem_req_ready) begin
                  mem_req_valid_r <= 1'b0;
                  state_r         <= WAIT0;
               end
            end
            WAIT0: begin
               if (mem_rsp_valid) begin
                  word0_r <= mem_rsp_data;
                  if (cross_r) begin
                     state_r         <= ISSUE1;
                     mem_req_valid_r <= 1'b1;
                     mem_req_addr_r  <= base_r + XLEN'(WB);
                  end else begin
                     state_r     <= RESP;
                     rsp_valid_r <= 1'b1;
                     rsp_err_r   <= 1'b0;
                     rsp_data_r  <= extract_f(fn3_r, off_r, mem_rsp_data, {XLEN{1'b0}});
                     rsp_rd_r    <= rd_r;
                  end
               end
            end
            ISSUE1: begin
               if (mem_req_ready) begin
                  mem_req_valid_r <= 1'b0;
                  state_r         <= WAIT1;
               end
            end
            WAIT1: begin
               if (mem_rsp_valid) begin
                  state_r     <= RESP;
                  rsp_valid_r <= 1'b1;
                  rsp_err_r   <= 1'b0;
                  rsp_data_r  <= extract_f(fn3_r, off_r, word0_r, mem_rsp_data);
                  rsp_rd_r    <= rd_r;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  req_ready_r <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r         <= IDLE;
               req_ready_r     <= 1'b1;
               mem_req_valid_r <= 1'b0;
               rsp_valid_r     <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready     = req_ready_r;
   assign mem_req_valid = mem_req_valid_r;
   assign mem_req_addr  = mem_req_addr_r;
   assign rsp_valid     = rsp_valid_r;
   assign rsp_data      = rsp_data_r;
   assign rsp_rd        = rsp_rd_r;
   assign rsp_err       = rsp_err_r;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a split-capable instance and a
// misalign-rejecting instance, both with XLEN=32.
module tb_load_align_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_valid0;
   logic [2:0]  req_fn3;
   logic [31:0] req_addr;
   logic [4:0]  req_rd;
   logic        mem_req_ready;
   logic        mem_rsp_valid, mem_rsp_valid0;
   logic [31:0] mem_rsp_data;
   logic        rsp_ready;

   logic        req_ready, mem_req_valid, rsp_valid, rsp_err;
   logic [31:0] mem_req_addr, rsp_data;
   logic [4:0]  rsp_rd;
   logic        req_ready0, mem_req_valid0, rsp_valid0, rsp_err0;
   logic [31:0] mem_req_addr0, rsp_data0;
   logic [4:0]  rsp_rd0;

   int total = 0;
   int bad   = 0;

   logic [31:0] ma0, md0, ma1, md1;

   load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_fn3(req_fn3),
      .req_addr(req_addr), .req_rd(req_rd),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
      .mem_rsp_data(mem_rsp_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_rd(rsp_rd), .rsp_err(rsp_err)
   );

   load_align_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_fn3(req_fn3),
      .req_addr(req_addr), .req_rd(req_rd),
      .mem_req_valid(mem_req_valid0), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr0), .mem_rsp_valid(mem_rsp_valid0),
      .mem_rsp_data(mem_rsp_data),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_data(rsp_data0),
      .rsp_rd(rsp_rd0), .rsp_err(rsp_err0)
   );

   task automatic chk(input string t1, input string t2, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s.%s observed=%h expected=%h", t1, t2, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] memrd(input logic [31:0] a);
      if (a === ma0) return md0;
      else if (a === ma1) return md1;
      else return 32'h0BAD0BAD;
   endfunction

   // One complete load on the split-capable instance with a zero-wait memory.
   task automatic do_load(input string tag, input logic [2:0] fn3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input int exp_nreq,
                          input logic [31:0] exp_a0, input logic [31:0] exp_a1);
      int          cyc;
      int          nreq;
      logic        pend;
      logic [31:0] pend_addr;
      logic [31:0] a0;
      logic [31:0] a1;
      chk(tag, "req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_fn3 = fn3; req_addr = addr; req_rd = rd;
      tick();
      req_valid = 1'b0;
      cyc = 1; nreq = 0; pend = 1'b0; pend_addr = 32'h0; a0 = 32'h0; a1 = 32'h0;
      while (rsp_valid !== 1'b1 && cyc < 30) begin
         mem_rsp_valid = pend;
         mem_rsp_data  = pend ? memrd(pend_addr) : 32'h0;
         pend = 1'b0;
         if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            pend = 1'b1;
            pend_addr = mem_req_addr;
            if (nreq == 0) a0 = mem_req_addr;
            else a1 = mem_req_addr;
            nreq++;
         end
         tick();
         cyc++;
      end
      mem_rsp_valid = 1'b0;
      chk(tag, "latency", 32'(cyc), 32'(exp_lat));
      chk(tag, "nreq", 32'(nreq), 32'(exp_nreq));
      chk(tag, "addr0", a0, exp_a0);
      chk(tag, "addr1", a1, exp_a1);
      chk(tag, "data", rsp_data, exp_data);
      chk(tag, "err", 32'(rsp_err), 32'(exp_err));
      chk(tag, "rd", 32'(rsp_rd), 32'(rd));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk(tag, "rsp_drop", 32'(rsp_valid), 32'd0);
      chk(tag, "idle", 32'(req_ready), 32'd1);
   endtask

   // Rejected request on the non-splitting instance: one-cycle error response, no memory traffic.
   task automatic do_err0(input string tag, input logic [2:0] fn3, input logic [31:0] addr, input logic [4:0] rd);
      chk(tag, "req_ready", 32'(req_ready0), 32'd1);
      req_valid0 = 1'b1; req_fn3 = fn3; req_addr = addr; req_rd = rd;
      tick();
      req_valid0 = 1'b0;
      chk(tag, "valid", 32'(rsp_valid0), 32'd1);
      chk(tag, "err", 32'(rsp_err0), 32'd1);
      chk(tag, "data", rsp_data0, 32'h0);
      chk(tag, "rd", 32'(rsp_rd0), 32'(rd));
      chk(tag, "memreq", 32'(mem_req_valid0), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk(tag, "rsp_drop", 32'(rsp_valid0), 32'd0);
      chk(tag, "memreq2", 32'(mem_req_valid0), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0; req_fn3 = 3'b000;
      req_addr = 32'h0; req_rd = 5'd0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
      mem_rsp_valid0 = 1'b0; mem_rsp_data = 32'h0; rsp_ready = 1'b0;
      ma0 = 32'h0; md0 = 32'h0; ma1 = 32'h1; md1 = 32'h0;
      tick();
      chk("reset", "req_ready", 32'(req_ready), 32'd1);
      chk("reset", "mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("reset", "mem_req_addr", mem_req_addr, 32'h0);
      chk("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset", "rsp_err", 32'(rsp_err), 32'd0);
      chk("reset", "rsp_data", rsp_data, 32'h0);
      chk("reset", "rsp_rd", 32'(rsp_rd), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      ma0 = 32'h100; md0 = 32'hDEADBEEF;
      do_load("lw_aligned", 3'b010, 32'h100, 5'd1, 32'hDEADBEEF, 1'b0, 3, 1, 32'h100, 32'h0);

      md0 = 32'h80123456;
      do_load("lb_103",  3'b000, 32'h103, 5'd2, 32'hFFFFFF80, 1'b0, 3, 1, 32'h100, 32'h0);
      do_load("lbu_103", 3'b100, 32'h103, 5'd3, 32'h00000080, 1'b0, 3, 1, 32'h100, 32'h0);
      do_load("lhu_102", 3'b101, 32'h102, 5'd4, 32'h00008012, 1'b0, 3, 1, 32'h100, 32'h0);
      do_load("lh_102",  3'b001, 32'h102, 5'd5, 32'hFFFF8012, 1'b0, 3, 1, 32'h100, 32'h0);
      do_load("lb_101",  3'b000, 32'h101, 5'd6, 32'h00000034, 1'b0, 3, 1, 32'h100, 32'h0);
      do_load("lh_100",  3'b001, 32'h100, 5'd7, 32'h00003456, 1'b0, 3, 1, 32'h100, 32'h0);

      ma0 = 32'h0FC; md0 = 32'hAABBCCDD; ma1 = 32'h100; md1 = 32'h11223344;
      do_load("lw_split", 3'b010, 32'h0FE, 5'd8, 32'h3344AABB, 1'b0, 5, 2, 32'h0FC, 32'h100);
      do_load("lh_split", 3'b001, 32'h0FF, 5'd9, 32'h000044AA, 1'b0, 5, 2, 32'h0FC, 32'h100);

      ma0 = 32'hFFFFFFFC; md0 = 32'h89ABCDEF; ma1 = 32'h0; md1 = 32'h01234567;
      do_load("lw_wrap", 3'b010, 32'hFFFFFFFE, 5'd10, 32'h456789AB, 1'b0, 5, 2, 32'hFFFFFFFC, 32'h0);

      do_load("fn3_111", 3'b111, 32'h100, 5'd11, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
      do_load("ld_rv32", 3'b011, 32'h100, 5'd12, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);

      do_err0("nomis_lh_0ff", 3'b001, 32'h0FF, 5'd13);
      do_err0("nomis_fn3_111", 3'b111, 32'h100, 5'd14);

      // Back-pressure on both the memory request and the response.
      ma0 = 32'h100; md0 = 32'hCAFEF00D; ma1 = 32'h1; md1 = 32'h0;
      mem_req_ready = 1'b0;
      req_valid = 1'b1; req_fn3 = 3'b010; req_addr = 32'h100; req_rd = 5'd15;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp_mem", "valid", 32'(mem_req_valid), 32'd1);
         chk("bp_mem", "addr", mem_req_addr, 32'h100);
         chk("bp_mem", "req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      mem_req_ready = 1'b1;
      chk("bp_mem", "valid_hs", 32'(mem_req_valid), 32'd1);
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = md0;
      tick();
      mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_rsp", "valid", 32'(rsp_valid), 32'd1);
         chk("bp_rsp", "data", rsp_data, 32'hCAFEF00D);
         chk("bp_rsp", "rd", 32'(rsp_rd), 32'd15);
         chk("bp_rsp", "req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      chk("bp_rsp", "valid_hs", 32'(rsp_valid), 32'd1);
      tick();
      rsp_ready = 1'b0;
      chk("bp_rsp", "rsp_drop", 32'(rsp_valid), 32'd0);
      chk("bp_rsp", "idle", 32'(req_ready), 32'd1);

      // Reset while waiting for read data; the late response must be ignored.
      req_valid = 1'b1; req_fn3 = 3'b010; req_addr = 32'h100; req_rd = 5'd16;
      tick();
      req_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #2;
      chk("rst_wait0", "mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_wait0", "rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
      tick();
      mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
      for (int i = 0; i < 3; i++) begin
         chk("rst_wait0", "no_rsp", 32'(rsp_valid), 32'd0);
         chk("rst_wait0", "req_ready", 32'(req_ready), 32'd1);
         tick();
      end
      do_load("post_rst", 3'b010, 32'h100, 5'd17, 32'hCAFEF00D, 1'b0, 3, 1, 32'h100, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
